fsab_arbiter: RTL and testbench

- Shares one FSAB slave port (e.g. the simulation memory or DRAM controller) between NMASTERS FSAB masters.
- Buffers each master's request bursts and issues whole bursts downstream under downstream credit control, round-robin between masters.
- Returns credits upstream per master.
- The fsabi return path is broadcast to all masters; each master filters on did.

---
 rtl/fsab_arbiter_pkg.sv | 30 +++
 rtl/fsab_arbiter_fifo.sv | 94 +++++++++
 rtl/fsab_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fsab_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsab_arbiter_pkg.sv
// Shared FSAB widths, arbiter FSM encodings and the buffered beat record.
package fsab_arbiter_pkg;
    localparam int FSAB_REQ_HI          = 0;
    localparam int FSAB_DID_HI          = 3;
    localparam int FSAB_ADDR_HI         = 30;
    localparam int FSAB_LEN_HI          = 3;
    localparam int FSAB_DATA_HI         = 63;
    localparam int FSAB_MASK_HI         = 7;
    localparam int FSAB_CREDITS_HI      = 1;
    localparam int FSAB_INITIAL_CREDITS = 4;
    localparam int FSAB_LEN_MAX         = 8;

    localparam logic [FSAB_REQ_HI:0] FSAB_READ  = 1'b0;
    localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = 1'b1;

    localparam logic [0:0] FSAB_ARB_ST_IDLE  = 1'b0;
    localparam logic [0:0] FSAB_ARB_ST_BURST = 1'b1;

    typedef struct packed {
        logic [FSAB_REQ_HI:0]  mode;
        logic [FSAB_DID_HI:0]  did;
        logic [FSAB_DID_HI:0]  subdid;
        logic [FSAB_ADDR_HI:0] addr;
        logic [FSAB_LEN_HI:0]  len;
        logic [FSAB_DATA_HI:0] data;
        logic [FSAB_MASK_HI:0] mask;
    } fsab_beat_t;

    localparam int FSAB_ARB_REC_W = $bits(fsab_beat_t);
endpackage

// File: rtl/fsab_arbiter_fifo.sv
// Per-master beat FIFO: marks request boundaries on ingress, counts complete
// requests, and presents popped beats one cycle after the pop.
module fsab_arb_fifo import fsab_arbiter_pkg::*; #(
    parameter int DEPTH = FSAB_INITIAL_CREDITS * FSAB_LEN_MAX
) (
    input  logic                      clk,
    input  logic                      Nrst,
    input  logic                      push,
    input  logic [FSAB_ARB_REC_W-1:0] push_beat,
    input  logic                      pop,
    input  logic                      take,
    output logic [FSAB_ARB_REC_W-1:0] beat,
    output logic                      beat_last,
    output logic                      head_last,
    output logic                      ready,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(DEPTH + 1);
    localparam logic [FSAB_LEN_HI:0] LEN_ONE = 1;

    fsab_beat_t                in_b;
    logic [FSAB_ARB_REC_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]          last_mem;
    logic [AW:0]               wptr, rptr;
    logic [FSAB_LEN_HI:0]      remain, remain_nxt;
    logic [RW-1:0]             ready_reqs, ready_nxt;
    logic                      full, do_push, push_last;

    // Top pointer bit is a lap flag so full and empty stay distinguishable.
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1)) return {~p[AW], {AW{1'b0}}};
        return {p[AW], p[AW-1:0] + AW'(1)};
    endfunction

    assign in_b      = push_beat;
    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push   = push && (!full || pop);
    assign head_last = last_mem[rptr[AW-1:0]];
    assign ready     = (ready_reqs != '0);

    always_comb begin
        push_last  = 1'b1;
        remain_nxt = '0;
        if (remain == '0) begin
            if (in_b.mode == FSAB_WRITE && in_b.len > LEN_ONE) begin
                push_last  = 1'b0;
                remain_nxt = in_b.len - LEN_ONE;
            end
        end else begin
            push_last  = (remain == LEN_ONE);
            remain_nxt = remain - LEN_ONE;
        end
    end

    always_comb begin
        case ({do_push && push_last, take})
            2'b10:   ready_nxt = ready_reqs + RW'(1);
            2'b01:   ready_nxt = ready_reqs - RW'(1);
            default: ready_nxt = ready_reqs;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]]      <= push_beat;
            last_mem[wptr[AW-1:0]] <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!Nrst) begin
            wptr       <= '0;
            rptr       <= '0;
            remain     <= '0;
            ready_reqs <= '0;
            beat       <= '0;
            beat_last  <= 1'b0;
        end else begin
            if (push && full && !pop) $error("fsab_arb_fifo: push while full, beat dropped");
            if (do_push) begin
                wptr   <= ptr_inc(wptr);
                remain <= remain_nxt;
            end
            if (pop) begin
                beat      <= mem[rptr[AW-1:0]];
                beat_last <= last_mem[rptr[AW-1:0]];
                rptr      <= ptr_inc(rptr);
            end
            ready_reqs <= ready_nxt;
        end
    end
endmodule

// File: rtl/fsab_arbiter.sv
// Round-robin arbiter sharing one FSAB slave among NMASTERS masters; whole
// bursts are issued under downstream credit control.
module fsab_arbiter import fsab_arbiter_pkg::*; #(
    parameter int NMASTERS   = 2,
    parameter int FIFO_BEATS = FSAB_INITIAL_CREDITS * FSAB_LEN_MAX
) (
    input  logic                                   clk,
    input  logic                                   Nrst,
    input  logic [NMASTERS-1:0]                    m_fsabo_valid,
    input  logic [NMASTERS*(FSAB_REQ_HI+1)-1:0]    m_fsabo_mode,
    input  logic [NMASTERS*(FSAB_DID_HI+1)-1:0]    m_fsabo_did,
    input  logic [NMASTERS*(FSAB_DID_HI+1)-1:0]    m_fsabo_subdid,
    input  logic [NMASTERS*(FSAB_ADDR_HI+1)-1:0]   m_fsabo_addr,
    input  logic [NMASTERS*(FSAB_LEN_HI+1)-1:0]    m_fsabo_len,
    input  logic [NMASTERS*(FSAB_DATA_HI+1)-1:0]   m_fsabo_data,
    input  logic [NMASTERS*(FSAB_MASK_HI+1)-1:0]   m_fsabo_mask,
    output logic [NMASTERS-1:0]                    m_fsabo_credit,
    output logic                                   m_fsabi_valid,
    output logic [FSAB_DID_HI:0]                   m_fsabi_did,
    output logic [FSAB_DID_HI:0]                   m_fsabi_subdid,
    output logic [FSAB_DATA_HI:0]                  m_fsabi_data,
    output logic                                   s_fsabo_valid,
    output logic [FSAB_REQ_HI:0]                   s_fsabo_mode,
    output logic [FSAB_DID_HI:0]                   s_fsabo_did,
    output logic [FSAB_DID_HI:0]                   s_fsabo_subdid,
    output logic [FSAB_ADDR_HI:0]                  s_fsabo_addr,
    output logic [FSAB_LEN_HI:0]                   s_fsabo_len,
    output logic [FSAB_DATA_HI:0]                  s_fsabo_data,
    output logic [FSAB_MASK_HI:0]                  s_fsabo_mask,
    input  logic                                   s_fsabo_credit,
    input  logic                                   s_fsabi_valid,
    input  logic [FSAB_DID_HI:0]                   s_fsabi_did,
    input  logic [FSAB_DID_HI:0]                   s_fsabi_subdid,
    input  logic [FSAB_DATA_HI:0]                  s_fsabi_data
);
    localparam int GW  = $clog2(NMASTERS);
    localparam int DW  = FSAB_CREDITS_HI + 2;
    localparam int MW  = FSAB_REQ_HI + 1;
    localparam int IW  = FSAB_DID_HI + 1;
    localparam int AW  = FSAB_ADDR_HI + 1;
    localparam int LW  = FSAB_LEN_HI + 1;
    localparam int XW  = FSAB_DATA_HI + 1;
    localparam int KW  = FSAB_MASK_HI + 1;

    logic [NMASTERS-1:0][FSAB_ARB_REC_W-1:0] fifo_beat;
    logic [NMASTERS-1:0] fifo_last, head_last, ready, fifo_empty, pop, take;
    logic [0:0]          state;
    logic [GW-1:0]       grant, last_grant, winner;
    logic [DW-1:0]       dcred;
    logic                win_valid, start, pop_done, s_valid, burst_end;
    int                  idx;
    fsab_beat_t          head;

    for (genvar i = 0; i < NMASTERS; i++) begin : g_m
        fsab_beat_t in_b;
        assign in_b.mode   = m_fsabo_mode[i*MW +: MW];
        assign in_b.did    = m_fsabo_did[i*IW +: IW];
        assign in_b.subdid = m_fsabo_subdid[i*IW +: IW];
        assign in_b.addr   = m_fsabo_addr[i*AW +: AW];
        assign in_b.len    = m_fsabo_len[i*LW +: LW];
        assign in_b.data   = m_fsabo_data[i*XW +: XW];
        assign in_b.mask   = m_fsabo_mask[i*KW +: KW];

        fsab_arb_fifo #(.DEPTH(FIFO_BEATS)) u_fifo (
            .clk       (clk),
            .Nrst      (Nrst),
            .push      (m_fsabo_valid[i]),
            .push_beat (in_b),
            .pop       (pop[i]),
            .take      (take[i]),
            .beat      (fifo_beat[i]),
            .beat_last (fifo_last[i]),
            .head_last (head_last[i]),
            .ready     (ready[i]),
            .empty     (fifo_empty[i])
        );
    end

    always_comb begin
        win_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int k = 1; k <= NMASTERS; k++) begin
            idx = (int'(last_grant) + k) % NMASTERS;
            if (!win_valid && ready[GW'(idx)]) begin
                win_valid = 1'b1;
                winner    = GW'(idx);
            end
        end
    end

    assign start     = (state == FSAB_ARB_ST_IDLE) && win_valid && (dcred != '0);
    assign burst_end = (state == FSAB_ARB_ST_BURST) && s_valid && fifo_last[grant];

    always_comb begin
        pop  = '0;
        take = '0;
        if (start) begin
            pop[winner]  = 1'b1;
            take[winner] = 1'b1;
        end else if (state == FSAB_ARB_ST_BURST && !pop_done) begin
            pop[grant] = 1'b1;
        end
    end

    always_comb begin
        m_fsabo_credit = '0;
        if (burst_end) m_fsabo_credit[grant] = 1'b1;
    end

    // Each FIFO's output register holds its last popped beat, so muxing by grant is registered data.
    assign head           = fifo_beat[grant];
    assign s_fsabo_valid  = s_valid;
    assign s_fsabo_mode   = head.mode;
    assign s_fsabo_did    = head.did;
    assign s_fsabo_subdid = head.subdid;
    assign s_fsabo_addr   = head.addr;
    assign s_fsabo_len    = head.len;
    assign s_fsabo_data   = head.data;
    assign s_fsabo_mask   = head.mask;

    assign m_fsabi_valid  = s_fsabi_valid;
    assign m_fsabi_did    = s_fsabi_did;
    assign m_fsabi_subdid = s_fsabi_subdid;
    assign m_fsabi_data   = s_fsabi_data;

    always_ff @(posedge clk) begin
        if (!Nrst) begin
            state      <= FSAB_ARB_ST_IDLE;
            grant      <= '0;
            last_grant <= GW'(NMASTERS - 1);
            pop_done   <= 1'b0;
            s_valid    <= 1'b0;
            dcred      <= DW'(FSAB_INITIAL_CREDITS);
        end else begin
            if (|(pop & fifo_empty)) $error("fsab_arbiter: pop from empty FIFO");
            s_valid <= |pop;
            case (state)
                FSAB_ARB_ST_IDLE: if (start) begin
                    grant    <= winner;
                    pop_done <= head_last[winner];
                    state    <= FSAB_ARB_ST_BURST;
                end
                default: begin
                    if (!pop_done) pop_done <= head_last[grant];
                    if (burst_end) begin
                        last_grant <= grant;
                        state      <= FSAB_ARB_ST_IDLE;
                    end
                end
            endcase
            if (start && !s_fsabo_credit) begin
                dcred <= dcred - DW'(1);
            end else if (!start && s_fsabo_credit) begin
                if (dcred == DW'(FSAB_INITIAL_CREDITS)) $error("fsab_arbiter: downstream credit overflow");
                else dcred <= dcred + DW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fsab_arbiter.sv
// Directed scenario bench for fsab_arbiter with hand-computed expectations.
module tb_fsab_arbiter;
    import fsab_arbiter_pkg::*;

    localparam int NM = 2;
    localparam int MW = FSAB_REQ_HI + 1;
    localparam int IW = FSAB_DID_HI + 1;
    localparam int AW = FSAB_ADDR_HI + 1;
    localparam int LW = FSAB_LEN_HI + 1;
    localparam int XW = FSAB_DATA_HI + 1;
    localparam int KW = FSAB_MASK_HI + 1;

    logic clk = 1'b0;
    logic Nrst = 1'b0;
    logic [NM-1:0]      m_fsabo_valid = '0;
    logic [NM*MW-1:0]   m_fsabo_mode = '0;
    logic [NM*IW-1:0]   m_fsabo_did = '0, m_fsabo_subdid = '0;
    logic [NM*AW-1:0]   m_fsabo_addr = '0;
    logic [NM*LW-1:0]   m_fsabo_len = '0;
    logic [NM*XW-1:0]   m_fsabo_data = '0;
    logic [NM*KW-1:0]   m_fsabo_mask = '0;
    logic [NM-1:0]      m_fsabo_credit;
    logic               m_fsabi_valid;
    logic [IW-1:0]      m_fsabi_did, m_fsabi_subdid;
    logic [XW-1:0]      m_fsabi_data;
    logic               s_fsabo_valid;
    logic [MW-1:0]      s_fsabo_mode;
    logic [IW-1:0]      s_fsabo_did, s_fsabo_subdid;
    logic [AW-1:0]      s_fsabo_addr;
    logic [LW-1:0]      s_fsabo_len;
    logic [XW-1:0]      s_fsabo_data;
    logic [KW-1:0]      s_fsabo_mask;
    logic               s_fsabo_credit = 1'b0;
    logic               s_fsabi_valid = 1'b0;
    logic [IW-1:0]      s_fsabi_did = '0, s_fsabi_subdid = '0;
    logic [XW-1:0]      s_fsabi_data = '0;

    int total = 0, bad = 0, ncyc = 0;
    logic auto_cred = 1'b0;
    logic [IW-1:0] log_did[$];
    logic [XW-1:0] log_data[$];
    logic [KW-1:0] log_mask[$];
    logic [NM-1:0] log_cred[$];
    int            log_cyc[$];

    fsab_arbiter #(.NMASTERS(NM)) dut (
        .clk(clk), .Nrst(Nrst),
        .m_fsabo_valid(m_fsabo_valid), .m_fsabo_mode(m_fsabo_mode),
        .m_fsabo_did(m_fsabo_did), .m_fsabo_subdid(m_fsabo_subdid),
        .m_fsabo_addr(m_fsabo_addr), .m_fsabo_len(m_fsabo_len),
        .m_fsabo_data(m_fsabo_data), .m_fsabo_mask(m_fsabo_mask),
        .m_fsabo_credit(m_fsabo_credit),
        .m_fsabi_valid(m_fsabi_valid), .m_fsabi_did(m_fsabi_did),
        .m_fsabi_subdid(m_fsabi_subdid), .m_fsabi_data(m_fsabi_data),
        .s_fsabo_valid(s_fsabo_valid), .s_fsabo_mode(s_fsabo_mode),
        .s_fsabo_did(s_fsabo_did), .s_fsabo_subdid(s_fsabo_subdid),
        .s_fsabo_addr(s_fsabo_addr), .s_fsabo_len(s_fsabo_len),
        .s_fsabo_data(s_fsabo_data), .s_fsabo_mask(s_fsabo_mask),
        .s_fsabo_credit(s_fsabo_credit),
        .s_fsabi_valid(s_fsabi_valid), .s_fsabi_did(s_fsabi_did),
        .s_fsabi_subdid(s_fsabi_subdid), .s_fsabi_data(s_fsabi_data)
    );

    always #5 clk = ~clk;

    // One clock; outputs are sampled 1 time unit after the edge and logged.
    task automatic cyc();
        @(posedge clk);
        #1;
        ncyc++;
        if (s_fsabo_valid) begin
            log_did.push_back(s_fsabo_did);
            log_data.push_back(s_fsabo_data);
            log_mask.push_back(s_fsabo_mask);
            log_cred.push_back(m_fsabo_credit);
            log_cyc.push_back(ncyc);
        end
        if (auto_cred) s_fsabo_credit = |m_fsabo_credit;
    endtask

    task automatic clear_log();
        log_did.delete(); log_data.delete(); log_mask.delete();
        log_cred.delete(); log_cyc.delete();
    endtask

    task automatic drive(input int m, input logic v, input logic [MW-1:0] mode,
                         input logic [IW-1:0] did, input logic [AW-1:0] addr,
                         input logic [LW-1:0] len, input logic [XW-1:0] data,
                         input logic [KW-1:0] mask);
        m_fsabo_valid[m]           = v;
        m_fsabo_mode[m*MW +: MW]   = mode;
        m_fsabo_did[m*IW +: IW]    = did;
        m_fsabo_subdid[m*IW +: IW] = did;
        m_fsabo_addr[m*AW +: AW]   = addr;
        m_fsabo_len[m*LW +: LW]    = len;
        m_fsabo_data[m*XW +: XW]   = data;
        m_fsabo_mask[m*KW +: KW]   = mask;
    endtask

    task automatic idle_inputs();
        m_fsabo_valid = '0;
    endtask

    // Returns edges waited until s_fsabo_valid, or -1 on timeout.
    task automatic wait_valid(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            cyc();
            if (s_fsabo_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Nrst = 1'b0;
        cyc(); cyc();
        total++; if (s_fsabo_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", s_fsabo_valid); end
        total++; if (m_fsabo_credit !== 2'b00) begin bad++; $display("FAIL reset_credit: got %0b want 0", m_fsabo_credit); end
        total++; if (dut.dcred !== 3'd4) begin bad++; $display("FAIL reset_dcred: got %0d want 4", dut.dcred); end
        total++; if (dut.fifo_empty !== 2'b11) begin bad++; $display("FAIL reset_empty: got %0b want 11", dut.fifo_empty); end
        Nrst = 1'b1;
        cyc();
    endtask

    task automatic test_return_path();
        s_fsabi_valid = 1'b1; s_fsabi_did = 4'h5; s_fsabi_subdid = 4'hA;
        s_fsabi_data = 64'hDEAD_BEEF_0123_4567;
        #1;
        total++; if (m_fsabi_valid !== 1'b1) begin bad++; $display("FAIL fsabi_valid: got %0b want 1", m_fsabi_valid); end
        total++; if (m_fsabi_did !== 4'h5) begin bad++; $display("FAIL fsabi_did: got %0h want 5", m_fsabi_did); end
        total++; if (m_fsabi_subdid !== 4'hA) begin bad++; $display("FAIL fsabi_subdid: got %0h want a", m_fsabi_subdid); end
        total++; if (m_fsabi_data !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL fsabi_data: got %0h want deadbeef01234567", m_fsabi_data); end
        s_fsabi_valid = 1'b0;
    endtask

    task automatic test_single_read();
        int lat;
        drive(0, 1'b1, FSAB_READ, 4'h1, 31'h100, 4'd8, 64'h0, 8'hFF);
        cyc();
        idle_inputs();
        wait_valid(10, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL read_latency: got %0d want 1", lat); end
        total++; if (s_fsabo_addr !== 31'h100 || s_fsabo_did !== 4'h1) begin
            bad++; $display("FAIL read_hdr: got addr %0h did %0h want 100/1", s_fsabo_addr, s_fsabo_did); end
        total++; if (s_fsabo_mode !== FSAB_READ || s_fsabo_len !== 4'd8) begin
            bad++; $display("FAIL read_mode_len: got %0h/%0d want 0/8", s_fsabo_mode, s_fsabo_len); end
        total++; if (m_fsabo_credit !== 2'b01) begin bad++; $display("FAIL read_credit: got %0b want 01", m_fsabo_credit); end
        total++; if (dut.dcred !== 3'd3) begin bad++; $display("FAIL read_dcred: got %0d want 3", dut.dcred); end
        cyc();
        total++; if (s_fsabo_valid !== 1'b0 || m_fsabo_credit !== 2'b00) begin
            bad++; $display("FAIL read_after: got valid %0b credit %0b want 0/0", s_fsabo_valid, m_fsabo_credit); end
        s_fsabo_credit = 1'b1;
        cyc();
        s_fsabo_credit = 1'b0;
        total++; if (dut.dcred !== 3'd4) begin bad++; $display("FAIL read_refill: got %0d want 4", dut.dcred); end
    endtask

    task automatic test_write_burst();
        auto_cred = 1'b1;
        clear_log();
        for (int j = 0; j < 8; j++) begin
            drive(1, 1'b1, FSAB_WRITE, 4'h2, 31'h200, 4'd8, 64'h1000 + 64'(j), 8'(8'h10 + j));
            cyc();
        end
        idle_inputs();
        repeat (15) cyc();
        total++; if (log_did.size() !== 8) begin bad++; $display("FAIL wr_count: got %0d want 8", log_did.size()); end
        else begin
            for (int j = 0; j < 8; j++) begin
                total++; if (log_data[j] !== 64'h1000 + 64'(j) || log_mask[j] !== 8'(8'h10 + j)) begin
                    bad++; $display("FAIL wr_beat%0d: got %0h/%0h want %0h/%0h", j, log_data[j], log_mask[j], 64'h1000 + 64'(j), 8'h10 + j); end
                total++; if (log_cyc[j] !== log_cyc[0] + j) begin
                    bad++; $display("FAIL wr_contig%0d: got cycle %0d want %0d", j, log_cyc[j], log_cyc[0] + j); end
                total++; if (log_cred[j] !== ((j == 7) ? 2'b10 : 2'b00)) begin
                    bad++; $display("FAIL wr_credit%0d: got %0b want %0b", j, log_cred[j], (j == 7) ? 2'b10 : 2'b00); end
            end
        end
        total++; if (dut.dcred !== 3'd4) begin bad++; $display("FAIL wr_dcred: got %0d want 4", dut.dcred); end
    endtask

    task automatic test_contention();
        logic [IW-1:0] exp_did [6] = '{4'h4, 4'h5, 4'h4, 4'h5, 4'h4, 4'h5};
        clear_log();
        for (int j = 0; j < 3; j++) begin
            drive(0, 1'b1, FSAB_READ, 4'h4, 31'h300 + 31'(j), 4'd1, 64'h0, 8'h0);
            drive(1, 1'b1, FSAB_READ, 4'h5, 31'h400 + 31'(j), 4'd1, 64'h0, 8'h0);
            cyc();
        end
        idle_inputs();
        repeat (20) cyc();
        total++; if (log_did.size() !== 6) begin bad++; $display("FAIL rr_count: got %0d want 6", log_did.size()); end
        else begin
            for (int j = 0; j < 6; j++) begin
                total++; if (log_did[j] !== exp_did[j]) begin
                    bad++; $display("FAIL rr_order%0d: got did %0h want %0h", j, log_did[j], exp_did[j]); end
            end
        end
    endtask

    task automatic test_starvation();
        int lat;
        auto_cred = 1'b0;
        clear_log();
        for (int j = 0; j < 5; j++) begin
            drive(0, 1'b1, FSAB_READ, 4'(j), 31'h500, 4'd2, 64'h0, 8'h0);
            cyc();
        end
        idle_inputs();
        repeat (20) cyc();
        total++; if (log_did.size() !== 4) begin bad++; $display("FAIL starve_count: got %0d want 4", log_did.size()); end
        total++; if (dut.dcred !== 3'd0) begin bad++; $display("FAIL starve_dcred: got %0d want 0", dut.dcred); end
        s_fsabo_credit = 1'b1;
        cyc();
        s_fsabo_credit = 1'b0;
        wait_valid(10, lat);
        total++; if (lat < 1 || lat > 2) begin bad++; $display("FAIL starve_release: got %0d want 1..2", lat); end
        total++; if (s_fsabo_did !== 4'h4) begin bad++; $display("FAIL starve_did: got %0h want 4", s_fsabo_did); end
        s_fsabo_credit = 1'b1;
        repeat (4) cyc();
        s_fsabo_credit = 1'b0;
        cyc();
        total++; if (dut.dcred !== 3'd4) begin bad++; $display("FAIL starve_refill: got %0d want 4", dut.dcred); end
    endtask

    task automatic test_interleave();
        int lat;
        auto_cred = 1'b1;
        clear_log();
        for (int j = 0; j < 8; j++) begin
            drive(0, 1'b1, FSAB_WRITE, 4'h7, 31'h600, 4'd8, 64'h3000 + 64'(j), 8'hFF);
            cyc();
        end
        idle_inputs();
        wait_valid(10, lat);
        total++; if (lat < 0) begin bad++; $display("FAIL ilv_start: got timeout want beat"); end
        drive(1, 1'b1, FSAB_READ, 4'h8, 31'h700, 4'd4, 64'h0, 8'h0);
        cyc();
        idle_inputs();
        repeat (20) cyc();
        total++; if (log_did.size() !== 9) begin bad++; $display("FAIL ilv_count: got %0d want 9", log_did.size()); end
        else begin
            for (int j = 0; j < 8; j++) begin
                total++; if (log_did[j] !== 4'h7) begin bad++; $display("FAIL ilv_m0_beat%0d: got did %0h want 7", j, log_did[j]); end
            end
            total++; if (log_did[8] !== 4'h8) begin bad++; $display("FAIL ilv_m1: got did %0h want 8", log_did[8]); end
            total++; if (log_cyc[8] - log_cyc[7] !== 2) begin bad++; $display("FAIL ilv_gap: got %0d want 2", log_cyc[8] - log_cyc[7]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat;
        auto_cred = 1'b1;
        clear_log();
        for (int j = 0; j < 8; j++) begin
            drive(0, 1'b1, FSAB_WRITE, 4'h9, 31'h800, 4'd8, 64'h4000 + 64'(j), 8'hFF);
            cyc();
        end
        idle_inputs();
        for (int k = 0; k < 30 && log_did.size() < 3; k++) cyc();
        total++; if (log_did.size() !== 3) begin bad++; $display("FAIL rst_mid_reach: got %0d beats want 3", log_did.size()); end
        Nrst = 1'b0;
        cyc();
        total++; if (s_fsabo_valid !== 1'b0 || m_fsabo_credit !== 2'b00) begin
            bad++; $display("FAIL rst_mid_out: got valid %0b credit %0b want 0/0", s_fsabo_valid, m_fsabo_credit); end
        total++; if (dut.dcred !== 3'd4) begin bad++; $display("FAIL rst_mid_dcred: got %0d want 4", dut.dcred); end
        total++; if (dut.fifo_empty !== 2'b11) begin bad++; $display("FAIL rst_mid_empty: got %0b want 11", dut.fifo_empty); end
        Nrst = 1'b1;
        drive(1, 1'b1, FSAB_READ, 4'hA, 31'h40, 4'd1, 64'h0, 8'h0);
        cyc();
        idle_inputs();
        wait_valid(10, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL post_rst_latency: got %0d want 1", lat); end
        total++; if (s_fsabo_did !== 4'hA || m_fsabo_credit !== 2'b10) begin
            bad++; $display("FAIL post_rst_beat: got did %0h credit %0b want a/10", s_fsabo_did, m_fsabo_credit); end
        repeat (3) cyc();
        total++; if (s_fsabo_valid !== 1'b0) begin bad++; $display("FAIL post_rst_quiet: got %0b want 0", s_fsabo_valid); end
    endtask

    initial begin
        test_reset();
        test_return_path();
        test_single_read();
        test_write_burst();
        test_contention();
        test_starvation();
        test_interleave();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
